inv_key_expansion: RTL and testbench
====================================

Name: inv_key_expansion

Overview:
- Iterative inverse AES-128 key schedule for the decryption datapath.
- Accepts the final round key and walks the schedule backwards, one round per accepted output.
- Emits round keys NUM_ROUNDS down to 0 in the order the inverse cipher consumes them.
- Each inverse step is the exact inverse of the team's combinational key_expansion step, optionally with FIPS-197 Rcon.

Parameters:
- DATA_WIDTH, 128, key width; only 128 supported.
- BYTE, 8, byte width.
- NUM_ROUNDS, 10, index of the last round key, which is the loaded key.
- RCON_EN, 0, 0 = no Rcon (exact inverse of key_expansion); 1 = FIPS-197 Rcon XOR.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  key_in valid.
- in_ready  out  1  block idle and able to accept a key.
- key_in  in  DATA_WIDTH  round key NUM_ROUNDS; column c at bits [32c+31:32c], byte b of a column at bits [8b+7:8b].
- out_valid  out  1  round_key_out valid.
- out_ready  in  1  consumer accepts round_key_out.
- round_key_out  out  DATA_WIDTH  current round key.
- round_idx  out  4  round index of round_key_out.
- out_last  out  1  high with round_idx==0.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_last=0, round_key_out=0, round_idx=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid: key_reg<=key_in, round_idx<=NUM_ROUNDS, go RUN.
  - RUN: in_ready=0, out_valid=1. A transfer is out_valid&&out_ready.
    - Transfer with round_idx>0: key_reg<=inv_step(key_reg, rcon[round_idx]); round_idx decrements.
    - Transfer with round_idx==0: go IDLE, out_valid drops next cycle.
- Latency and throughput:
  - First output is valid the cycle after acceptance.
  - With out_ready held high: 11 back-to-back outputs, then in_ready=1 on the next cycle.
- Stall: out_ready=0 holds round_key_out, round_idx and out_last stable; no state change.
- in_valid during RUN is ignored; no queuing.
- Reset asserted mid-sequence clears immediately. No partial output persists.
- inv_step(K) with columns c0..c3:
  - p3=c3^c2, p2=c2^c1, p1=c1^c0.
  - p0=c0^rot(sub(p3))^rc.
- sub: byte-wise through four s_box instances (byte_in/s_byte_out) applied to p3 bytes s0..s3.
- rot: result byte b = s[(b+1) mod 4]. Matches {s0,s3,s2,s1} packing of bits[31:0].
- Rcon:
  - rc = rcon[r] in byte 0 (bits [7:0]) of column 0 when RCON_EN=1, else 0.
  - rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, indexed by the round being undone.
- Datapath is purely combinational from key_reg. round_key_out=key_reg (registered output).
- out_last = out_valid && round_idx==0.

Test Plan:
- FIPS-197 vector, RCON_EN=1, out_ready=1, key_in=a60c63b6c80c3fe18925eec9a8f914d0:
  - cycle+1: round_idx=10, same key.
  - next: round_idx=9, key 6e005c574129d12821dcfa19f36677ac.
  - 11th output: round_idx=0, key 3c4fcf098815f7aba6d2ae2816157e2b, out_last=1.
  - in_ready=1 one cycle later.
- Round-trip, RCON_EN=0, random keys:
  - Feeding each round_key_out(r-1) into key_expansion returns round_key_out(r) for all r.
  - Feeding the round-0 key into key_expansion ten times returns key_in.
- Backpressure: toggle out_ready pseudo-randomly.
  - Outputs stay stable while stalled.
  - Exactly 11 transfers occur, in order 10..0, with no duplicates or skips.
- Busy rejection: pulse in_valid with a different key during RUN.
  - The sequence is unaffected.
  - A new key is accepted only after the round-0 transfer.
- Async reset: assert rst_n=0 mid-sequence, between clock edges, at round_idx=5.
  - Outputs clear immediately to reset values.
  - After release, in_ready=1 and a fresh FIPS run matches the first scenario.
- Reset idle: no in_valid for 20 cycles -> out_valid stays 0 and in_ready stays 1.

Source files
------------

// File: rtl/inv_key_expansion_if.sv
// Handshake bundle for the inverse AES-128 key schedule: key load on the
// in_* side, round-key stream on the out_* side.
interface inv_key_expansion_if #(
    parameter int DATA_WIDTH = 128
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] key_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] round_key_out;
    logic [3:0]            round_idx;
    logic                  out_last;

    modport master (
        output in_valid, key_in, out_ready,
        input  in_ready, out_valid, round_key_out, round_idx, out_last
    );

    modport slave (
        input  in_valid, key_in, out_ready,
        output in_ready, out_valid, round_key_out, round_idx, out_last
    );
endinterface

// File: rtl/inv_key_expansion.sv
// AES forward S-box lookup (byte substitution table).
module s_box (
    input  logic [7:0] byte_in,
    output logic [7:0] s_byte_out
);
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    assign s_byte_out = SBOX[byte_in];
endmodule

// Iterative inverse AES-128 key schedule: loads the last round key and walks
// backwards one round per accepted output, emitting rounds NUM_ROUNDS..0.
module inv_key_expansion #(
    parameter int DATA_WIDTH = 128,
    parameter int BYTE       = 8,
    parameter int NUM_ROUNDS = 10,
    parameter int RCON_EN    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inv_key_expansion_if.slave   bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] key_reg, key_d;
    logic [3:0]            idx_reg, idx_d;

    logic [31:0] c0, c1, c2, c3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] sub_w, rot_w;
    logic [7:0]  rc_byte;

    // Round constant for the round currently being undone (rcon[1..10]).
    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign c0 = key_reg[31:0];
    assign c1 = key_reg[63:32];
    assign c2 = key_reg[95:64];
    assign c3 = key_reg[127:96];

    // Columns 1..3 of the previous key fall out of neighbour XORs; p3 is the
    // previous column 3, which feeds the SubWord/RotWord term for column 0.
    assign p3 = c3 ^ c2;
    assign p2 = c2 ^ c1;
    assign p1 = c1 ^ c0;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        s_box u_sbox (
            .byte_in    (p3[BYTE*b +: BYTE]),
            .s_byte_out (sub_w[BYTE*b +: BYTE])
        );
    end

    // Byte b of the rotated word is substituted byte (b+1) mod 4.
    assign rot_w   = {sub_w[7:0], sub_w[31:24], sub_w[23:16], sub_w[15:8]};
    assign rc_byte = (RCON_EN != 0) ? rcon_of(idx_reg) : 8'h00;
    assign p0      = c0 ^ rot_w ^ {24'h000000, rc_byte};

    // State, key and round index registers; reset clears everything visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_reg <= '0;
            idx_reg <= '0;
        end else begin
            state_q <= state_d;
            key_reg <= key_d;
            idx_reg <= idx_d;
        end
    end

    // Next-state logic: load in IDLE, step back one round per output transfer.
    always_comb begin
        state_d      = state_q;
        key_d        = key_reg;
        idx_d        = idx_reg;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    key_d   = bus.key_in;
                    idx_d   = 4'(NUM_ROUNDS);
                    state_d = RUN;
                end
            end
            RUN: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    if (idx_reg != 4'd0) begin
                        key_d = {p3, p2, p1, p0};
                        idx_d = idx_reg - 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.round_key_out = key_reg;
    assign bus.round_idx     = idx_reg;
    assign bus.out_last      = bus.out_valid && (idx_reg == 4'd0);
endmodule

// File: tb/tb_inv_key_expansion.sv
// Scoreboard bench for inv_key_expansion: two instances (Rcon on / off) run in
// lockstep from shared stimulus; a FIPS-style word-recurrence model supplies
// the expected round keys.
module tb_inv_key_expansion;
    localparam logic [127:0] FIPS_K  = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
    localparam logic [127:0] FIPS_R9 = 128'h6e005c574129d12821dcfa19f36677ac;
    localparam logic [127:0] FIPS_R0 = 128'h3c4fcf098815f7aba6d2ae2816157e2b;

    typedef struct packed {
        logic [127:0] key;
        logic [3:0]   idx;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, out_ready;
    logic [127:0] key_in;
    int           checks = 0;
    int           errors = 0;
    logic [7:0]   sb_tab [0:255];
    exp_t         q0[$], q1[$];
    logic         prev_stall [2];
    logic [127:0] held_key [2];
    logic [3:0]   held_idx [2];
    logic         held_last [2];
    logic [127:0] prev_key [2];
    logic [127:0] acc_key [2];

    inv_key_expansion_if #(.DATA_WIDTH(128)) bus0 ();
    inv_key_expansion_if #(.DATA_WIDTH(128)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.key_in    = key_in;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.key_in    = key_in;
    assign bus1.out_ready = out_ready;

    inv_key_expansion #(.DATA_WIDTH(128), .BYTE(8), .NUM_ROUNDS(10), .RCON_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    inv_key_expansion #(.DATA_WIDTH(128), .BYTE(8), .NUM_ROUNDS(10), .RCON_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    // ---------------- reference model (GF(2^8) arithmetic) ----------------
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r ^= aa;
            aa = xtime(aa);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    function automatic logic [7:0] rcon_ref(input int r);
        logic [7:0] x = 8'h01;
        for (int i = 1; i < r; i++) x = xtime(x);
        return x;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Forward key-expansion step (word recurrence) used for round-trip checks.
    function automatic logic [127:0] fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [7:0] w [0:7][0:3];
        logic [127:0] r;
        for (int j = 0; j < 4; j++)
            for (int b = 0; b < 4; b++) w[j][b] = k[32*j + 8*b +: 8];
        for (int j = 4; j < 8; j++)
            for (int b = 0; b < 4; b++)
                if (j == 4) w[j][b] = w[0][b] ^ sb_tab[w[3][(b+1)%4]] ^ ((b == 0) ? rc : 8'h00);
                else        w[j][b] = w[j-4][b] ^ w[j-1][b];
        for (int j = 0; j < 4; j++)
            for (int b = 0; b < 4; b++) r[32*j + 8*b +: 8] = w[j+4][b];
        return r;
    endfunction

    // Rebuild the whole 44-word schedule backwards from the last round key and
    // queue the 11 round keys in the order the cipher consumes them.
    task automatic push_exp(input int d, input logic [127:0] k);
        logic [7:0] w [0:43][0:3];
        exp_t e;
        for (int j = 0; j < 4; j++)
            for (int b = 0; b < 4; b++) w[40+j][b] = k[32*j + 8*b +: 8];
        for (int i = 43; i >= 4; i--)
            for (int b = 0; b < 4; b++)
                if (i % 4 != 0) w[i-4][b] = w[i][b] ^ w[i-1][b];
                else w[i-4][b] = w[i][b] ^ sb_tab[w[i-1][(b+1)%4]]
                                 ^ ((b == 0 && d == 1) ? rcon_ref(i/4) : 8'h00);
        for (int r = 10; r >= 0; r--) begin
            for (int j = 0; j < 4; j++)
                for (int b = 0; b < 4; b++) e.key[32*j + 8*b +: 8] = w[4*r + j][b];
            e.idx  = 4'(r);
            e.last = (r == 0);
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    // ---------------- acceptance and output monitors ----------------
    task automatic acc(input int d, input logic iv, input logic ir, input logic [127:0] k);
        if (iv && ir) begin
            check($sformatf("accept_after_drain%0d", d), (d == 0) ? q0.size() : q1.size(), 0);
            push_exp(d, k);
            acc_key[d] = k;
        end
    endtask

    task automatic mon(input int d, input logic ov, input logic ordy, input logic [127:0] k,
                       input logic [3:0] idx, input logic last);
        exp_t e;
        logic [127:0] x;
        check($sformatf("out_last_rule%0d", d), last, ov && (idx == 4'd0));
        if (prev_stall[d]) begin
            check($sformatf("stall_key%0d", d), k, held_key[d]);
            check($sformatf("stall_idx%0d", d), idx, held_idx[d]);
            check($sformatf("stall_last%0d", d), last, held_last[d]);
        end
        if (ov && ordy) begin
            if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out%0d: got idx %0d key %h expected none", d, idx, k);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("key%0d_r%0d", d, e.idx), k, e.key);
                check($sformatf("idx%0d", d), idx, e.idx);
                check($sformatf("last%0d", d), last, e.last);
                if (e.idx != 4'd10)
                    check($sformatf("roundtrip%0d_r%0d", d, e.idx),
                          fwd(k, (d == 1) ? rcon_ref(int'(e.idx) + 1) : 8'h00), prev_key[d]);
                if (e.idx == 4'd0) begin
                    x = k;
                    for (int r = 1; r <= 10; r++) x = fwd(x, (d == 1) ? rcon_ref(r) : 8'h00);
                    check($sformatf("roundtrip10_%0d", d), x, acc_key[d]);
                end
                prev_key[d] = k;
            end
        end
        prev_stall[d] = ov && !ordy;
        held_key[d]   = k;
        held_idx[d]   = idx;
        held_last[d]  = last;
    endtask

    always @(negedge clk) if (rst_n) acc(0, bus0.in_valid, bus0.in_ready, bus0.key_in);
    always @(negedge clk) if (rst_n) acc(1, bus1.in_valid, bus1.in_ready, bus1.key_in);
    always @(negedge clk) if (rst_n)
        mon(0, bus0.out_valid, bus0.out_ready, bus0.round_key_out, bus0.round_idx, bus0.out_last);
    always @(negedge clk) if (rst_n)
        mon(1, bus1.out_valid, bus1.out_ready, bus1.round_key_out, bus1.round_idx, bus1.out_last);

    // ---------------- stimulus ----------------
    task automatic load(input logic [127:0] k);
        @(posedge clk); #1;
        in_valid = 1'b1;
        key_in   = k;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus1.in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
        end
        check("load_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic run_idle(input bit rnd);
        bit done = 0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            done = bus1.in_ready && bus0.in_ready && q0.size() == 0 && q1.size() == 0;
        end
        check("sequence_complete", done, 1);
        out_ready = 1'b1;
    endtask

    task automatic reset_vals(input string tag);
        check({tag, "_ov1"}, bus1.out_valid, 0);
        check({tag, "_ir1"}, bus1.in_ready, 1);
        check({tag, "_last1"}, bus1.out_last, 0);
        check({tag, "_key1"}, bus1.round_key_out, 0);
        check({tag, "_idx1"}, bus1.round_idx, 0);
        check({tag, "_ov0"}, bus0.out_valid, 0);
        check({tag, "_key0"}, bus0.round_key_out, 0);
    endtask

    task automatic fips_run();
        out_ready = 1'b1;
        load(FIPS_K);
        @(negedge clk);
        check("fips_idx10", bus1.round_idx, 10);
        check("fips_key10", bus1.round_key_out, FIPS_K);
        @(negedge clk);
        check("fips_idx9", bus1.round_idx, 9);
        check("fips_key9", bus1.round_key_out, FIPS_R9);
        repeat (9) @(negedge clk);
        check("fips_idx0", bus1.round_idx, 0);
        check("fips_key0", bus1.round_key_out, FIPS_R0);
        check("fips_last", bus1.out_last, 1);
        @(negedge clk);
        check("fips_in_ready_after", bus1.in_ready, 1);
        check("fips_out_valid_after", bus1.out_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        key_in    = '0;
        for (int d = 0; d < 2; d++) begin
            prev_stall[d] = 1'b0;
            prev_key[d]   = '0;
            acc_key[d]    = '0;
        end
        build_sbox();
        repeat (3) @(negedge clk);
        reset_vals("reset");
        #2 rst_n = 1'b1;

        // Idle with no load: nothing must appear.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_out_valid", bus1.out_valid | bus0.out_valid, 0);
            check("idle_in_ready", bus1.in_ready & bus0.in_ready, 1);
        end

        fips_run();

        // Random keys with random backpressure.
        for (int n = 0; n < 4; n++) begin
            load({$urandom, $urandom, $urandom, $urandom});
            run_idle(1);
        end

        // Busy rejection: a pulse during RUN is ignored, a held request waits.
        load({$urandom, $urandom, $urandom, $urandom});
        in_valid = 1'b1;
        key_in   = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        in_valid = 1'b0;
        load({$urandom, $urandom, $urandom, $urandom});
        run_idle(1);

        // Asynchronous reset in the middle of a sequence.
        out_ready = 1'b1;
        load(FIPS_K);
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            found = (bus1.round_idx == 4'd5);
        end
        check("reached_round5", found, 1);
        #2 rst_n = 1'b0;
        #1 reset_vals("midreset");
        q0.delete();
        q1.delete();
        prev_stall[0] = 1'b0;
        prev_stall[1] = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", bus1.in_ready, 1);
        fips_run();
        run_idle(0);

        check("final_q0_empty", q0.size(), 0);
        check("final_q1_empty", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
